arithmetic_unit: RTL and testbench
==================================

# arithmetic_unit

Registered 4-bit arithmetic unit of the ALU datapath. Each cycle it adds operand A to a selected transform of operand B (B, ~B, all-zeros or all-ones) plus a carry-in, giving add, subtract, transfer/increment and decrement. The sum and carry-out are registered on the rising clock edge. It sits beside the logic unit and feeds the ALU output mux.

## Interface

Clocking and reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`).

Parameters:
- WIDTH, default 4, operand and result width in bits. The test plan values below use WIDTH = 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- A  input  WIDTH  first operand, unsigned
- B  input  WIDTH  second operand, unsigned
- S  input  2  operation select
- C_in  input  1  carry-in, added at bit 0
- result  output  WIDTH  registered sum, modulo 2^WIDTH
- C_out  output  1  registered carry-out of bit WIDTH-1

## Operation

- Y is chosen combinationally from S:
  - S=00: Y = B
  - S=01: Y = ~B (bitwise)
  - S=10: Y = 0
  - S=11: Y = all ones (2^WIDTH − 1)
- The full (WIDTH+1)-bit sum is A + Y + C_in, all operands zero-extended.
  - result = sum[WIDTH-1:0]
  - C_out = sum[WIDTH]
- Operation set:
  - S=00, C_in=0: A+B
  - S=00, C_in=1: A+B+1
  - S=01, C_in=0: A−B−1
  - S=01, C_in=1: A−B (two's complement). Here C_out=1 means no borrow (A ≥ B).
  - S=10, C_in=0: transfer A, C_out=0
  - S=10, C_in=1: A+1. C_out=1 only when A is all ones.
  - S=11, C_in=0: A−1. C_out=0 only when A=0.
  - S=11, C_in=1: transfer A, C_out=1
- Implement as a ripple chain of WIDTH full adders. Bit i has inputs A[i], Y[i] and the carry from bit i−1; bit 0 takes C_in.
- No overflow or sign flags. Wrap-around is modulo 2^WIDTH, with the carry reported only through C_out.
- All 2^(2·WIDTH+3) input combinations are legal. There are no illegal or reserved select codes.

## Timing

- At each rising clk:
  - if rst=1: result ← 0, C_out ← 0
  - else: result and C_out are loaded from the combinational sum of that cycle's A, B, S, C_in.
- Reset value of every output: result = 0, C_out = 0.
- Latency is 1 cycle, fully pipelined. A new operation is accepted every cycle, with no handshake and no stall.
- Reset takes priority over any input. Asserting rst mid-stream discards the pending sum. The first valid result appears one cycle after rst deasserts with inputs applied.
- Outputs hold their value between edges. Input changes between edges do not affect the outputs until the next edge.

## Test plan

- Reset: hold rst=1 for 2 cycles with A=1111, B=1111, S=00, C_in=1 -> result=0000, C_out=0 at every edge. Release rst -> next edge gives result=1111, C_out=1.
- Add:
  - A=0101, B=0011, S=00, C_in=0 -> result=1000, C_out=0 after 1 cycle.
  - A=1111, B=0001, S=00, C_in=1 -> result=0001, C_out=1.
- Subtract:
  - A=0111, B=0011, S=01, C_in=1 -> result=0100, C_out=1.
  - A=0010, B=0101, S=01, C_in=1 -> result=1101, C_out=0 (borrow).
- Increment/transfer:
  - A=1111, S=10, C_in=1 -> result=0000, C_out=1.
  - A=1010, S=10, C_in=0 -> result=1010, C_out=0.
- Decrement:
  - A=0000, S=11, C_in=0 -> result=1111, C_out=0.
  - A=0101, S=11, C_in=0 -> result=0100, C_out=1.
  - A=0101, S=11, C_in=1 -> result=0101, C_out=1.
- Exhaustive: step the 11-bit vector {A, B, S, C_in} from 0 to 2047, one value per cycle. Each output, one cycle later, must equal the model A + Y(S, B) + C_in, split into result and C_out.

Source files
------------

// File: rtl/arithmetic_unit.sv
// rtl/arithmetic_unit.sv - registered ripple-carry arithmetic unit of the ALU datapath
module arithmetic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       S,
  input  logic             C_in,
  output logic [WIDTH-1:0] result,
  output logic             C_out
);

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  // S selects B, ~B, zero or all-ones; with C_in this yields add/sub/inc/dec/transfer
  always_comb begin
    y = B;
    case (S)
      2'b00:   y = B;
      2'b01:   y = ~B;
      2'b10:   y = '0;
      default: y = '1;
    endcase
  end

  assign carry[0] = C_in;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = A[i] ^ y[i] ^ carry[i];
      assign carry[i+1] = (A[i] & y[i]) | (carry[i] & (A[i] ^ y[i]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      C_out  <= 1'b0;
    end else begin
      result <= sum;
      C_out  <= carry[WIDTH];
    end
  end

endmodule

// File: tb/tb_arithmetic_unit.sv
// tb/tb_arithmetic_unit.sv - directed and exhaustive checks of arithmetic_unit
module tb_arithmetic_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] S;
  logic       C_in;
  logic [3:0] result;
  logic       C_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arithmetic_unit #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .S      (S),
    .C_in   (C_in),
    .result (result),
    .C_out  (C_out)
  );

  task automatic chk(input string tag, input logic [4:0] exp);
    checks++;
    assert ({C_out, result} === exp) else begin
      failures++;
      $error("FAIL %s observed C_out,result=%b expected=%b", tag, {C_out, result}, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s, input logic c);
    A = a; B = b; S = s; C_in = c;
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: ~B treated as 15-B, zero as 0, all-ones as 15
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s, input logic c);
    int t;
    case (s)
      2'b00:   t = int'(a) + int'(b) + int'(c);
      2'b01:   t = int'(a) + (15 - int'(b)) + int'(c);
      2'b10:   t = int'(a) + int'(c);
      default: t = int'(a) + 15 + int'(c);
    endcase
    return 5'(t);
  endfunction

  initial begin
    rst = 1'b1;
    apply(4'b1111, 4'b1111, 2'b00, 1'b1);
    chk("reset_edge1", 5'b0_0000);
    apply(4'b1111, 4'b1111, 2'b00, 1'b1);
    chk("reset_edge2", 5'b0_0000);
    rst = 1'b0;
    apply(4'b1111, 4'b1111, 2'b00, 1'b1);
    chk("reset_release", 5'b1_1111);

    apply(4'b0101, 4'b0011, 2'b00, 1'b0);
    chk("add_5_3", 5'b0_1000);
    apply(4'b1111, 4'b0001, 2'b00, 1'b1);
    chk("add_15_1_cin", 5'b1_0001);
    apply(4'b0111, 4'b0011, 2'b01, 1'b1);
    chk("sub_7_3", 5'b1_0100);
    apply(4'b0010, 4'b0101, 2'b01, 1'b1);
    chk("sub_2_5_borrow", 5'b0_1101);
    apply(4'b1111, 4'b0000, 2'b10, 1'b1);
    chk("inc_15", 5'b1_0000);
    apply(4'b1010, 4'b0110, 2'b10, 1'b0);
    chk("transfer_a", 5'b0_1010);
    apply(4'b0000, 4'b1001, 2'b11, 1'b0);
    chk("dec_0", 5'b0_1111);
    apply(4'b0101, 4'b0000, 2'b11, 1'b0);
    chk("dec_5", 5'b1_0100);
    apply(4'b0101, 4'b0000, 2'b11, 1'b1);
    chk("transfer_a_cout", 5'b1_0101);
    apply(4'b0110, 4'b0100, 2'b01, 1'b0);
    chk("sub_minus1", 5'b1_0001);

    A = 4'b0001; B = 4'b0001; S = 2'b00; C_in = 1'b0;
    #3;
    chk("hold_between_edges", 5'b1_0001);

    rst = 1'b1;
    apply(4'b1111, 4'b1111, 2'b11, 1'b1);
    chk("reset_midstream", 5'b0_0000);
    rst = 1'b0;

    for (int v = 0; v < 2048; v++) begin
      logic [10:0] vec;
      vec = 11'(v);
      apply(vec[10:7], vec[6:3], vec[2:1], vec[0]);
      chk($sformatf("exh_%0d", v), model(vec[10:7], vec[6:3], vec[2:1], vec[0]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
